key_conditioner: RTL and testbench

//  Conditions raw, active-low, bouncing push-buttons (KEY0 start, KEY1 stop) before the reaction-timer FSM.
//  Per key: 2-FF synchronizer, ms-based debounce, and one-cycle press/release/long-press pulses.

---
 rtl/key_conditioner_pkg.sv | 24 ++
 rtl/key_conditioner_if.sv | 21 ++
 rtl/key_conditioner_key_channel.sv | 96 +++++++++
 rtl/key_conditioner.sv | 60 ++++++
 tb/tb_key_conditioner.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the reaction-timer key conditioner and the FSM that consumes it.
package key_conditioner_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 50000000;
    localparam int unsigned MS_DIV_DEFAULT = CLK_HZ_DEFAULT / 1000;

    // Key channel indices: bit i of every key vector is KEYi.
    localparam int unsigned KEY_START = 0;
    localparam int unsigned KEY_STOP  = 1;

    // Reaction-timer FSM states, kept here so the FSM and the conditioner agree.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_REACTION  = 2'd2,
        ST_DISPLAY   = 2'd3
    } rt_state_e;

    // Width of a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the board pins (master) and the conditioner (slave).
interface key_conditioner_if #(
    parameter int unsigned NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_raw_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic                tick_1ms;

    modport master (
        output key_raw_n,
        input  key_level, key_press, key_release, key_long, tick_1ms
    );

    modport slave (
        input  key_raw_n,
        output key_level, key_press, key_release, key_long, tick_1ms
    );
endinterface

// File: rtl/key_conditioner_key_channel.sv
// One key: 2-FF synchronizer, ms-based debounce, press/release/long-press pulses.
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_1ms,
    input  logic key_raw_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_MS);
    localparam int unsigned HW = cnt_width(LONG_MS);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          s;

    // Synchronizer shift and the synchronized, active-high key level.
    always_comb begin
        sync_d = {sync_q[0], key_raw_n};
        s      = ~sync_q[1];
    end

    // Debounce: a new level must persist for DEBOUNCE_MS ticks; any agreeing cycle restarts it.
    always_comb begin
        level_d = level_q;
        deb_d   = deb_q;
        if (s == level_q) begin
            deb_d = '0;
        end else if (tick_1ms) begin
            if (deb_q == DW'(DEBOUNCE_MS - 1)) begin
                level_d = s;
                deb_d   = '0;
            end else begin
                deb_d = deb_q + DW'(1);
            end
        end
    end

    // Edge pulses line up with the first cycle the new level is visible.
    always_comb begin
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    // Hold counter saturates at LONG_MS; key_long fires on the single step that reaches it.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q) begin
            hold_d = '0;
        end else if (tick_1ms && (hold_q != HW'(LONG_MS))) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_q == HW'(LONG_MS - 1));
        end
    end

    // State registers; raw pins reset to the released level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '1;
            level_q   <= 1'b0;
            deb_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            level_q   <= level_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner top: shared 1 ms prescaler fanned out to NUM_KEYS independent key channels.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 2,
    parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000
) (
    input logic              clk,
    input logic              reset_n,
    key_conditioner_if.slave bus
);

    localparam int unsigned MS_DIV = CLK_HZ / 1000;
    localparam int unsigned PW     = cnt_width(MS_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;

    // Prescaler counts 0..MS_DIV-1; the tick is registered so it appears the cycle after the wrap value.
    always_comb begin
        tick_d = (presc_q == PW'(MS_DIV - 1));
        if (tick_d) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Prescaler registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.tick_1ms = tick_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_key_channel (
            .clk         (clk),
            .reset_n     (reset_n),
            .tick_1ms    (tick_q),
            .key_raw_n   (bus.key_raw_n[i]),
            .key_level   (bus.key_level[i]),
            .key_press   (bus.key_press[i]),
            .key_release (bus.key_release[i]),
            .key_long    (bus.key_long[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: cycle-level reference model plus scenario checks.
module tb_key_conditioner;

    localparam int unsigned NK     = 2;
    localparam int unsigned CLK_HZ = 10000;
    localparam int unsigned DEB    = 4;
    localparam int unsigned LONG   = 20;
    localparam int unsigned DIV    = CLK_HZ / 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS    (NK),
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEB),
        .LONG_MS     (LONG)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (kif.slave)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state: pin history, ms elapsed, accepted level, ms of disagreement, ms held.
    logic [NK-1:0] m_pin1, m_pin2, m_level, m_press, m_rel, m_long;
    logic          m_tick;
    int            m_edges;
    int            m_mis  [NK];
    int            m_held [NK];

    // Observed DUT pulse statistics per scenario.
    int np [NK], nr [NK], nl [NK];
    int lastp [NK], lastr [NK], lastl [NK];
    int first_tick;
    int cyc = 0;
    int rel_cyc, edge_cyc, t;
    int unsigned d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pin1  = '1;
        m_pin2  = '1;
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        m_tick  = 1'b0;
        m_edges = 0;
        for (int k = 0; k < NK; k++) begin
            m_mis[k]  = 0;
            m_held[k] = 0;
        end
    endtask

    // One clock edge of the spec behaviour, using the values present before the edge.
    task automatic model_edge(input logic [NK-1:0] raw);
        logic tick_seen;
        logic pressed, was, now;
        tick_seen = m_tick;
        for (int k = 0; k < NK; k++) begin
            pressed = ~m_pin2[k];
            was     = m_level[k];
            now     = was;
            if (pressed == was) begin
                m_mis[k] = 0;
            end else if (tick_seen) begin
                m_mis[k] = m_mis[k] + 1;
                if (m_mis[k] == int'(DEB)) begin
                    now      = pressed;
                    m_mis[k] = 0;
                end
            end
            m_long[k] = 1'b0;
            if (!was) begin
                m_held[k] = 0;
            end else if (tick_seen && m_held[k] < int'(LONG)) begin
                m_held[k] = m_held[k] + 1;
                m_long[k] = (m_held[k] == int'(LONG));
            end
            m_press[k] = now & ~was;
            m_rel[k]   = was & ~now;
            m_level[k] = now;
        end
        m_pin2  = m_pin1;
        m_pin1  = raw;
        m_edges = m_edges + 1;
        m_tick  = ((m_edges % int'(DIV)) == 0);
    endtask

    task automatic clr();
        for (int k = 0; k < NK; k++) begin
            np[k] = 0; nr[k] = 0; nl[k] = 0;
            lastp[k] = -1; lastr[k] = -1; lastl[k] = -1;
        end
        first_tick = -1;
    endtask

    task automatic step();
        logic [NK-1:0] raw;
        raw = kif.key_raw_n;
        @(posedge clk);
        if (reset_n) model_edge(raw);
        else         model_reset();
        cyc++;
        #1;
        check("key_level",   32'(kif.key_level),   32'(m_level));
        check("key_press",   32'(kif.key_press),   32'(m_press));
        check("key_release", 32'(kif.key_release), 32'(m_rel));
        check("key_long",    32'(kif.key_long),    32'(m_long));
        check("tick_1ms",    32'(kif.tick_1ms),    32'(m_tick));
        for (int k = 0; k < NK; k++) begin
            if (kif.key_press[k])   begin np[k]++; lastp[k] = cyc; end
            if (kif.key_release[k]) begin nr[k]++; lastr[k] = cyc; end
            if (kif.key_long[k])    begin nl[k]++; lastl[k] = cyc; end
        end
        if (kif.tick_1ms && first_tick < 0) first_tick = cyc;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        #1;
        check("rst_async_outs",
              32'({kif.key_level, kif.key_press, kif.key_release, kif.key_long, kif.tick_1ms}), 32'(0));
        model_reset();
        repeat (n) step();
        reset_n = 1'b1;
        rel_cyc = cyc;
    endtask

    initial begin
        model_reset();
        clr();

        // 1: reset with both keys held down
        kif.key_raw_n = 2'b00;
        do_reset(3);
        clr();
        repeat (60) step();
        for (int k = 0; k < NK; k++) begin
            check("rst_press_cnt", 32'(np[k]), 32'(1));
            check("rst_press_win", 32'((lastp[k] - rel_cyc >= 32) && (lastp[k] - rel_cyc <= 43)), 32'(1));
        end
        check("rst_press_same", 32'(lastp[0] == lastp[1]), 32'(1));
        kif.key_raw_n = 2'b11;
        repeat (60) step();

        // 2: bounce on key0 with random intervals shorter than one ms
        clr();
        t = 0;
        edge_cyc = cyc;
        while (t < 200) begin
            d = $urandom_range(2, 9);
            kif.key_raw_n[0] = ~kif.key_raw_n[0];
            edge_cyc = cyc;
            repeat (d) step();
            t += int'(d);
        end
        check("bounce_no_press",   32'(np[0]), 32'(0));
        check("bounce_no_release", 32'(nr[0]), 32'(0));
        if (kif.key_raw_n[0]) begin
            kif.key_raw_n[0] = 1'b0;
            edge_cyc = cyc;
        end
        clr();
        repeat (50) step();
        check("bounce_press_cnt", 32'(np[0]), 32'(1));
        check("bounce_press_win", 32'(lastp[0] - edge_cyc <= 43), 32'(1));
        kif.key_raw_n[0] = 1'b1;
        repeat (60) step();

        // 3: clean long press
        clr();
        kif.key_raw_n[0] = 1'b0;
        repeat (300) step();
        kif.key_raw_n[0] = 1'b1;
        repeat (60) step();
        check("long_press_cnt",   32'(np[0]), 32'(1));
        check("long_long_cnt",    32'(nl[0]), 32'(1));
        check("long_release_cnt", 32'(nr[0]), 32'(1));
        check("long_delay",       32'(lastl[0] - lastp[0]), 32'(200));

        // 4: short press, random length below the long threshold
        clr();
        kif.key_raw_n[0] = 1'b0;
        d = $urandom_range(80, 150);
        repeat (d) step();
        kif.key_raw_n[0] = 1'b1;
        repeat (60) step();
        check("short_press_cnt",   32'(np[0]), 32'(1));
        check("short_release_cnt", 32'(nr[0]), 32'(1));
        check("short_no_long",     32'(nl[0]), 32'(0));

        // 5: both keys pressed in the same cycle
        clr();
        kif.key_raw_n = 2'b00;
        repeat (80) step();
        kif.key_raw_n = 2'b11;
        repeat (60) step();
        check("simul_press_cnt", 32'({np[1][3:0], np[0][3:0]}), 32'(8'h11));
        check("simul_press_same", 32'(lastp[0] == lastp[1]), 32'(1));
        check("simul_rel_same",   32'(lastr[0] == lastr[1]), 32'(1));

        // 6: reset pulsed 2 ms into a key0 press, key kept held
        kif.key_raw_n[0] = 1'b0;
        repeat (20) step();
        do_reset(2);
        clr();
        repeat (60) step();
        check("midrst_tick",      32'(first_tick - rel_cyc), 32'(10));
        check("midrst_press_cnt", 32'(np[0]), 32'(1));
        check("midrst_press_win", 32'((lastp[0] - rel_cyc >= 32) && (lastp[0] - rel_cyc <= 43)), 32'(1));
        check("midrst_key1_idle", 32'(np[1]), 32'(0));
        kif.key_raw_n = 2'b11;
        repeat (60) step();

        // Random activity on both keys, checked every cycle against the model
        repeat (1500) begin
            if ($urandom_range(0, 69) == 0) kif.key_raw_n[0] = ~kif.key_raw_n[0];
            if ($urandom_range(0, 8) == 0)  kif.key_raw_n[1] = ~kif.key_raw_n[1];
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
